tdc_meas_sequencer: RTL and testbench

Sequences measurements on the shared TDC core (one enable in; count and hasValue out) for several requesting channels. The block latches per-channel start requests and grants the core round-robin. It drives the core enable from start until that channel's stop event or a timeout, then collects the count. The result goes out tagged with its channel on a valid/ready port. It sits between the trigger/stop front-end and the result readout logic.

---
 rtl/tdc_pkg.sv | 27 ++
 rtl/tdc_rr_arbiter.sv | 33 +++
 rtl/tdc_meas_sequencer.sv | 167 ++++++++++++++++
 tb/tb_tdc_meas_sequencer.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and helpers for the TDC measurement sequencer
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        WAIT_RESULT,
        OUTPUT
    } state_e;

    // Index width for a channel count, never narrower than one bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RES_DATA_MAX_W = 64;
    localparam int RES_CH_MAX_W   = 3;

    // One measurement result, sized for the widest supported configuration
    typedef struct packed {
        logic [RES_DATA_MAX_W-1:0] data;
        logic [RES_CH_MAX_W-1:0]   channel;
        logic                      timeout;
    } tdc_result_t;

endpackage

// File: rtl/tdc_rr_arbiter.sv
// rtl/tdc_rr_arbiter.sv - round-robin channel pick starting after the last grant
module tdc_rr_arbiter
    import tdc_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CH_W     = ch_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] pending,
    input  logic [CH_W-1:0]     last_grant,
    output logic [CH_W-1:0]     grant,
    output logic                any_grant
);

    int idx;

    // Scan one full lap beginning just after last_grant; the first set bit wins
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int off = 1; off <= CHANNELS; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!any_grant && ((pending >> idx) & CHANNELS'(1)) != '0) begin
                any_grant = 1'b1;
                grant     = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tdc_meas_sequencer.sv
// rtl/tdc_meas_sequencer.sv - round-robin measurement sequencer for a shared TDC core
module tdc_meas_sequencer
    import tdc_pkg::*;
#(
    parameter int  CHANNELS       = 2,
    parameter int  BIT_COUNT      = 32,
    parameter int  TIMEOUT_CYCLES = 1024,
    parameter int  RESULT_WAIT    = 16,
    localparam int CH_W           = ch_w(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CHANNELS-1:0]  req,
    input  logic [CHANNELS-1:0]  stop,
    input  logic                 ovr_clear,
    output logic                 tdc_enable,
    input  logic [BIT_COUNT-1:0] tdc_count,
    input  logic                 tdc_hasValue,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BIT_COUNT-1:0] res_data,
    output logic [CH_W-1:0]      res_channel,
    output logic                 res_timeout,
    output logic                 busy,
    output logic [CHANNELS-1:0]  overrun
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > RESULT_WAIT) ? TIMEOUT_CYCLES : RESULT_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(RESULT_WAIT - 1);

    state_e               state_q, state_d;
    logic [CHANNELS-1:0]  pending_q, pending_d;
    logic [CHANNELS-1:0]  overrun_q, overrun_d;
    logic [CHANNELS-1:0]  grant_clear;
    logic [CH_W-1:0]      last_grant_q, last_grant_d;
    logic [CH_W-1:0]      channel_q, channel_d;
    logic [CH_W-1:0]      grant;
    logic                 any_grant;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 seen_low_q, seen_low_d;
    logic                 enable_q, enable_d;
    logic                 timeout_q, timeout_d;
    logic [BIT_COUNT-1:0] data_q, data_d;
    logic                 stop_sel;

    tdc_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_arb (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_grant  (any_grant)
    );

    // A grant in IDLE consumes its pending bit; a same-cycle request re-arms it without overrun
    assign grant_clear = (state_q == IDLE && any_grant) ? (CHANNELS'(1) << grant) : '0;
    assign pending_d   = (pending_q & ~grant_clear) | req;
    assign overrun_d   = (ovr_clear ? '0 : overrun_q) | (req & pending_q & ~grant_clear);

    // Only the channel currently being measured may end the measurement
    assign stop_sel = |(stop & (CHANNELS'(1) << channel_q));

    // Next-state and datapath updates for the measurement sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        channel_d    = channel_q;
        cnt_d        = cnt_q;
        seen_low_d   = seen_low_q;
        enable_d     = enable_q;
        timeout_d    = timeout_q;
        data_d       = data_q;

        // A stale high hasValue from the previous run must not be mistaken for a fresh result
        if ((state_q == MEASURE || state_q == WAIT_RESULT) && !tdc_hasValue) begin
            seen_low_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (any_grant) begin
                    channel_d = grant;
                    state_d   = ARM;
                end
            end
            ARM: begin
                enable_d   = 1'b1;
                cnt_d      = '0;
                seen_low_d = 1'b0;
                state_d    = MEASURE;
            end
            MEASURE: begin
                if (stop_sel) begin
                    enable_d  = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = WAIT_RESULT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    enable_d  = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RESULT: begin
                if (tdc_hasValue && seen_low_q) begin
                    data_d  = timeout_q ? '1 : tdc_count;
                    state_d = OUTPUT;
                end else if (cnt_q == WAIT_LAST) begin
                    data_d    = '1;
                    timeout_d = 1'b1;
                    state_d   = OUTPUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUTPUT: begin
                if (res_ready) begin
                    last_grant_d = channel_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops tdc_enable immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            overrun_q    <= '0;
            last_grant_q <= CH_W'(CHANNELS - 1);
            channel_q    <= '0;
            cnt_q        <= '0;
            seen_low_q   <= 1'b0;
            enable_q     <= 1'b0;
            timeout_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            last_grant_q <= last_grant_d;
            channel_q    <= channel_d;
            cnt_q        <= cnt_d;
            seen_low_q   <= seen_low_d;
            enable_q     <= enable_d;
            timeout_q    <= timeout_d;
            data_q       <= data_d;
        end
    end

    assign tdc_enable  = enable_q;
    assign res_valid   = (state_q == OUTPUT);
    assign res_data    = data_q;
    assign res_channel = channel_q;
    assign res_timeout = timeout_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// tb/tb_tdc_meas_sequencer.sv - randomized self-checking bench for tdc_meas_sequencer
module tb_tdc_meas_sequencer;
    import tdc_pkg::*;

    localparam int CHANNELS       = 2;
    localparam int BIT_COUNT      = 32;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int RESULT_WAIT    = 16;
    localparam logic [BIT_COUNT-1:0] ALL_ONES = '1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [CHANNELS-1:0]  req = '0;
    logic [CHANNELS-1:0]  stop = '0;
    logic                 ovr_clear = 1'b0;
    logic                 tdc_enable;
    logic [BIT_COUNT-1:0] tdc_count;
    logic                 tdc_hasValue = 1'b0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [BIT_COUNT-1:0] res_data;
    logic [0:0]           res_channel;
    logic                 res_timeout;
    logic                 busy;
    logic [CHANNELS-1:0]  overrun;

    int tests_run = 0;
    int tests_failed = 0;

    bit                   hv_never = 1'b0;
    int                   hv_delay = 2;
    int                   low_cnt = 100;
    logic [BIT_COUNT-1:0] core_count = '0;
    int                   model_last = CHANNELS - 1;

    tdc_meas_sequencer #(
        .CHANNELS       (CHANNELS),
        .BIT_COUNT      (BIT_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .RESULT_WAIT    (RESULT_WAIT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .stop         (stop),
        .ovr_clear    (ovr_clear),
        .tdc_enable   (tdc_enable),
        .tdc_count    (tdc_count),
        .tdc_hasValue (tdc_hasValue),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_channel  (res_channel),
        .res_timeout  (res_timeout),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // TDC core model: hasValue low while enabled, rises hv_delay cycles after enable falls
    always @(posedge clk) begin
        if (tdc_enable) begin
            low_cnt      <= 0;
            tdc_hasValue <= 1'b0;
        end else begin
            if (low_cnt < 1000) low_cnt <= low_cnt + 1;
            tdc_hasValue <= !hv_never && (low_cnt >= hv_delay);
        end
    end
    assign tdc_count = core_count;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: first pending channel scanning from last+1 with wrap
    function automatic int rr_pick(input logic [CHANNELS-1:0] pend, input int last);
        int c;
        for (int s = 1; s <= CHANNELS; s++) begin
            c = (last + s) % CHANNELS;
            if (((pend >> c) & CHANNELS'(1)) != '0) return c;
        end
        return -1;
    endfunction

    // Reference: result a measurement must produce
    function automatic tdc_result_t model_result(input int ch, input logic [BIT_COUNT-1:0] cnt,
                                                 input bit timed_out);
        tdc_result_t r;
        r = '0;
        r.channel = 3'(ch);
        r.timeout = timed_out;
        r.data    = timed_out ? {64{1'b1}} : 64'(cnt);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [CHANNELS-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic wait_enable(output int lat);
        lat = 0;
        while (!tdc_enable && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_enable(input int ch, input int stop_after, output int high);
        high = 0;
        while (tdc_enable && high < TIMEOUT_CYCLES + 20) begin
            if (stop_after > 0 && high == stop_after - 1) stop = CHANNELS'(1) << ch;
            tick();
            high++;
        end
        stop = '0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (tdc_enable !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || res_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got en=%b valid=%b busy=%b to=%b expected all 0",
                     tdc_enable, res_valid, busy, res_timeout);
        end
        tests_run++;
        if (res_data !== '0 || res_channel !== 1'b0 || overrun !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got data=%0h ch=%0d ovr=%b expected 0", res_data, res_channel, overrun);
        end
        reset_n = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b expected 0", busy);
        end
        model_last = CHANNELS - 1;
    endtask

    task automatic test_single();
        int lat, high, cyc;
        core_count = 32'd10000;
        hv_delay = 2;
        pulse_req(2'b01);
        wait_enable(lat);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d expected 2", lat);
        end
        run_enable(0, 10, high);
        tests_run++;
        if (high !== 10) begin
            tests_failed++;
            $display("FAIL single_enable_len: got %0d expected 10", high);
        end
        wait_valid(cyc);
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== 32'd10000 || res_channel !== 1'b0 || res_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_result: got v=%b d=%0d ch=%0d to=%b expected v=1 d=10000 ch=0 to=0",
                     res_valid, res_data, res_channel, res_timeout);
        end
        accept();
        model_last = 0;
        tests_run++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_accept: got v=%b busy=%b expected 0 0", res_valid, busy);
        end
    endtask

    task automatic test_random_measure();
        int ch, sd, lat, high, cyc, exp_high;
        bit exp_to;
        tdc_result_t exp;
        for (int n = 0; n < 6; n++) begin
            ch = $urandom_range(0, CHANNELS - 1);
            sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TIMEOUT_CYCLES - 1);
            core_count = $urandom;
            hv_delay = $urandom_range(0, 8);
            exp_to = (sd == 0);
            exp_high = exp_to ? TIMEOUT_CYCLES : sd;
            exp = model_result(ch, core_count, exp_to);
            pulse_req(CHANNELS'(1) << ch);
            wait_enable(lat);
            run_enable(ch, sd, high);
            tests_run++;
            if (lat !== 2 || high !== exp_high) begin
                tests_failed++;
                $display("FAIL rand_enable[%0d]: got lat=%0d high=%0d expected lat=2 high=%0d",
                         n, lat, high, exp_high);
            end
            wait_valid(cyc);
            tests_run++;
            if (res_valid !== 1'b1 || res_data !== exp.data[BIT_COUNT-1:0] ||
                res_channel !== exp.channel[0:0] || res_timeout !== exp.timeout) begin
                tests_failed++;
                $display("FAIL rand_result[%0d]: got v=%b d=%0h ch=%0d to=%b expected v=1 d=%0h ch=%0d to=%b",
                         n, res_valid, res_data, res_channel, res_timeout,
                         exp.data[BIT_COUNT-1:0], exp.channel, exp.timeout);
            end
            accept();
            model_last = ch;
        end
    endtask

    task automatic test_simultaneous();
        logic [CHANNELS-1:0] pend;
        int ch, sd, lat, high, cyc;
        tdc_result_t exp;
        pend = 2'b11;
        hv_delay = 1;
        pulse_req(pend);
        for (int n = 0; n < 2; n++) begin
            ch = rr_pick(pend, model_last);
            sd = $urandom_range(1, 20);
            core_count = $urandom;
            exp = model_result(ch, core_count, 1'b0);
            wait_enable(lat);
            run_enable(ch, sd, high);
            wait_valid(cyc);
            tests_run++;
            if (lat !== 2 || high !== sd || res_valid !== 1'b1 || res_channel !== exp.channel[0:0] ||
                res_data !== exp.data[BIT_COUNT-1:0] || res_timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL simul_order[%0d]: got lat=%0d high=%0d v=%b ch=%0d d=%0h expected lat=2 high=%0d v=1 ch=%0d d=%0h",
                         n, lat, high, res_valid, res_channel, res_data, sd, ch, exp.data[BIT_COUNT-1:0]);
            end
            accept();
            pend = pend & ~(CHANNELS'(1) << ch);
            model_last = ch;
        end
        tests_run++;
        if (overrun !== '0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_end: got ovr=%b busy=%b expected 00 0", overrun, busy);
        end
    endtask

    task automatic test_timeout();
        int lat, high, cyc;
        core_count = $urandom;
        pulse_req(2'b10);
        wait_enable(lat);
        run_enable(1, 0, high);
        tests_run++;
        if (high !== TIMEOUT_CYCLES) begin
            tests_failed++;
            $display("FAIL timeout_len: got %0d expected %0d", high, TIMEOUT_CYCLES);
        end
        wait_valid(cyc);
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== ALL_ONES || res_timeout !== 1'b1 || res_channel !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_result: got v=%b d=%0h to=%b ch=%0d expected v=1 d=%0h to=1 ch=1",
                     res_valid, res_data, res_timeout, res_channel, ALL_ONES);
        end
        accept();
        model_last = 1;
    endtask

    task automatic test_result_wait();
        int lat, high, cyc;
        core_count = $urandom;
        hv_never = 1'b1;
        pulse_req(2'b01);
        wait_enable(lat);
        run_enable(0, 5, high);
        wait_valid(cyc);
        tests_run++;
        if (cyc !== RESULT_WAIT) begin
            tests_failed++;
            $display("FAIL rwait_len: got %0d expected %0d", cyc, RESULT_WAIT);
        end
        tests_run++;
        if (res_valid !== 1'b1 || res_data !== ALL_ONES || res_timeout !== 1'b1 || res_channel !== 1'b0) begin
            tests_failed++;
            $display("FAIL rwait_result: got v=%b d=%0h to=%b ch=%0d expected v=1 d=%0h to=1 ch=0",
                     res_valid, res_data, res_timeout, res_channel, ALL_ONES);
        end
        accept();
        model_last = 0;
        hv_never = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_set_wins();
        int lat, high, cyc;
        hv_delay = 2;
        req = 2'b01;
        tick();
        tick();
        req = '0;
        tests_run++;
        if (overrun !== '0) begin
            tests_failed++;
            $display("FAIL setwins_ovr: got %b expected 00", overrun);
        end
        for (int n = 0; n < 2; n++) begin
            core_count = $urandom;
            wait_enable(lat);
            run_enable(0, 3 + n, high);
            wait_valid(cyc);
            tests_run++;
            if (lat !== (n == 0 ? 1 : 2) || res_valid !== 1'b1 || res_channel !== 1'b0 ||
                res_data !== core_count || res_timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL setwins_meas[%0d]: got lat=%0d v=%b ch=%0d d=%0h expected lat=%0d v=1 ch=0 d=%0h",
                         n, lat, res_valid, res_channel, res_data, (n == 0 ? 1 : 2), core_count);
            end
            accept();
            model_last = 0;
        end
    endtask

    task automatic test_overrun_backpressure();
        int lat, high, cyc;
        bit saw;
        tdc_result_t exp;
        core_count = $urandom;
        exp = model_result(0, core_count, 1'b0);
        pulse_req(2'b01);
        wait_enable(lat);
        pulse_req(2'b10);
        tick();
        pulse_req(2'b10);
        tests_run++;
        if (overrun !== 2'b10) begin
            tests_failed++;
            $display("FAIL ovr_set: got %b expected 10", overrun);
        end
        run_enable(0, 10, high);
        wait_valid(cyc);
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if (res_valid !== 1'b1 || res_data !== exp.data[BIT_COUNT-1:0] ||
                res_channel !== 1'b0 || res_timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%0h ch=%0d to=%b expected v=1 d=%0h ch=0 to=0",
                         i, res_valid, res_data, res_channel, res_timeout, exp.data[BIT_COUNT-1:0]);
            end
            tick();
        end
        accept();
        model_last = 0;
        core_count = $urandom;
        wait_enable(lat);
        run_enable(1, 7, high);
        wait_valid(cyc);
        tests_run++;
        if (lat !== 2 || res_valid !== 1'b1 || res_channel !== 1'b1 || res_data !== core_count) begin
            tests_failed++;
            $display("FAIL ovr_ch1: got lat=%0d v=%b ch=%0d d=%0h expected lat=2 v=1 ch=1 d=%0h",
                     lat, res_valid, res_channel, res_data, core_count);
        end
        accept();
        model_last = 1;
        saw = 1'b0;
        repeat (30) begin
            tick();
            if (tdc_enable) saw = 1'b1;
        end
        tests_run++;
        if (saw !== 1'b0 || busy !== 1'b0 || overrun !== 2'b10) begin
            tests_failed++;
            $display("FAIL ovr_single: got extra_meas=%b busy=%b ovr=%b expected 0 0 10", saw, busy, overrun);
        end
        ovr_clear = 1'b1;
        tick();
        ovr_clear = 1'b0;
        tests_run++;
        if (overrun !== '0) begin
            tests_failed++;
            $display("FAIL ovr_clear: got %b expected 00", overrun);
        end
    endtask

    task automatic test_reset_mid();
        int lat, high, cyc;
        bit saw;
        core_count = $urandom;
        pulse_req(2'b01);
        wait_enable(lat);
        repeat (3) tick();
        pulse_req(2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (tdc_enable !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got en=%b v=%b busy=%b expected 0 0 0", tdc_enable, res_valid, busy);
        end
        tick();
        reset_n = 1'b1;
        model_last = CHANNELS - 1;
        saw = 1'b0;
        repeat (10) begin
            tick();
            if (tdc_enable || busy) saw = 1'b1;
        end
        tests_run++;
        if (saw !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_pending: got activity=%b expected 0", saw);
        end
        core_count = $urandom;
        pulse_req(2'b01);
        wait_enable(lat);
        run_enable(0, 6, high);
        wait_valid(cyc);
        tests_run++;
        if (lat !== 2 || high !== 6 || res_valid !== 1'b1 || res_channel !== 1'b0 ||
            res_data !== core_count || res_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_fresh: got lat=%0d high=%0d v=%b ch=%0d d=%0h expected lat=2 high=6 v=1 ch=0 d=%0h",
                     lat, high, res_valid, res_channel, res_data, core_count);
        end
        accept();
        model_last = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_random_measure();
        test_simultaneous();
        test_timeout();
        test_result_wait();
        test_set_wins();
        test_overrun_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
